imm_stage: RTL
==============

# imm_stage

Registered, parametrised immediate-generation stage for the pipelined RV32I/RV64I core. It decodes the instruction format from the opcode itself rather than from a control code, and produces the sign-extended immediate, the format tag, an illegal-opcode flag and the PC-relative target `pc + imm`. It sits between fetch/decode and execute behind a valid/ready handshake with an optional 2-entry skid buffer and a synchronous flush for branch redirect.

## Interface
- `XLEN`, 32 — datapath width; legal values are 32 and 64.
- `SKID`, 1 — buffering mode.
  - 1: 2-entry skid buffer; `in_ready` is driven from a register.
  - 0: single output register; `in_ready = out_ready | ~out_valid`.

- `clk`  in  1  — clock; all state updates on the rising edge.
- `clrn`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — input beat valid.
- `in_ready`  out  1  — stage can accept a beat.
- `inst`  in  32  — instruction word.
- `pc`  in  XLEN  — PC of `inst`.
- `flush`  in  1  — synchronous kill of all held and incoming beats.
- `out_valid`  out  1  — output beat valid.
- `out_ready`  in  1  — downstream accepts the beat.
- `out_imm`  out  XLEN  — sign-extended immediate.
- `out_fmt`  out  3  — format tag: 0=N, 1=I, 2=SH, 3=S, 4=B, 5=U, 6=J. Code 7 is never produced.
- `out_target`  out  XLEN  — `pc + out_imm`, modulo 2^XLEN.
- `out_illegal`  out  1  — opcode not recognised.

## Operation
- Format decode from `inst[6:0]`:
  - 0010011: SH when funct3 is 001 or 101, otherwise I.
  - 0000011, 1100111, 1110011: I.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - 0110011, 0001111: N, with imm 0.
  - Any other opcode: N, imm 0, `out_illegal`=1.
- Immediate construction; every format is sign-extended from `inst[31]` to XLEN except SH:
  - I: `inst[31:20]`.
  - S: `{inst[31:25], inst[11:7]}`.
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
  - U: `{inst[31:12], 12'b0}`; when XLEN=64, bits 63:32 copy bit 31.
  - J: `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
  - SH: zero-extended; `inst[24:20]` when XLEN=32, `inst[25:20]` when XLEN=64.
- `out_target` is computed for every format. Downstream uses it only for B, J and AUIPC.
- Decode and add are done before the register. Skid entries hold results that are already computed.
- Handshake:
  - A beat transfers when valid and ready are both high on that side.
  - While `out_valid & ~out_ready`, all `out_*` outputs hold stable.
  - Beat order is preserved. No beat is dropped or duplicated.
- SKID=1: the primary register plus a skid register.
  - When the primary is stalled, an accepted beat goes to the skid register.
  - `in_ready` drops to 0 the cycle after the skid register fills.
  - `in_ready` returns to 1 the cycle after the skid register drains into the primary.
- Flush:
  - All entries are invalidated at the next edge.
  - Any input beat presented in the same cycle is discarded, even if `in_valid & in_ready`.
  - The next cycle has `out_valid`=0 and `in_ready`=1.
  - Flush has priority over every transfer.
- Reset (`clrn`=0, asynchronous):
  - `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_target`=0, `out_illegal`=0.
  - Skid register invalidated; `in_ready`=1 (SKID=1).
  - Reset in the middle of a stall discards all held beats.

## Timing
- Latency: a beat accepted at edge n appears on `out_*` with `out_valid`=1 after edge n.
- Throughput: 1 beat/cycle while `out_ready`=1.
- With SKID=1, there is no combinational path from `out_ready` to `in_ready`.
- With SKID=1, a simultaneous accept and output drain while the skid register is empty keeps `in_ready`=1 and bypasses the skid register.
- After a stall, the skid beat goes out the cycle after the primary beat is accepted.
- Flush and reset both give `out_valid`=0 in the following cycle. Reset also acts immediately (asynchronous).

## Test plan
- I and S formats, XLEN=32:
  - `inst`=0xFFF00093 → `out_imm`=0xFFFFFFFF, `out_fmt`=1.
  - `inst`=0xFE112E23 → `out_imm`=0xFFFFFFFC, `out_fmt`=3, one cycle after accept.
- B format with target: `inst`=0xFE000CE3, `pc`=0x100 → `out_imm`=0xFFFFFFF8, `out_fmt`=4, `out_target`=0xF8.
- J format with wrap: `inst`=0x0010006F, `pc`=0xFFFFF800 → `out_imm`=0x800, `out_fmt`=6, `out_target`=0x00000000.
- Shift and illegal:
  - `inst`=0x01F09093 → `out_imm`=0x1F, `out_fmt`=2.
  - `inst`=0x00000000 → `out_illegal`=1, `out_fmt`=0, `out_imm`=0.
- Backpressure, SKID=1:
  - Stimulus: hold `out_ready`=0 for 4 cycles while presenting 4 beats.
  - While held: `in_ready` falls after 2 beats are accepted, and `out_*` stay stable.
  - After release: the beats come out in order, back-to-back.
- Flush and reset:
  - Assert `flush` with 2 beats held and one beat presented → next cycle `out_valid`=0, `in_ready`=1, and none of the 3 beats ever appears.
  - Drop `clrn` mid-stall → all outputs read 0 immediately.

Source files
------------

// File: rtl/imm_stage.sv
// -----------------------------------------------------------------------------
// imm_stage
// Registered immediate-generation stage for the RV32I/RV64I pipeline.
// The instruction format is decoded directly from the opcode. The stage then
// produces four results:
//   - the sign-extended immediate,
//   - a format tag,
//   - an illegal-opcode flag,
//   - the PC-relative target pc + imm.
// All of these are computed before the output register.
// The beat is then held behind a valid/ready handshake. It uses either a
// 2-entry skid buffer (SKID=1) or a single output register (SKID=0).
//
// Parameters
//   XLEN  datapath width, 32 or 64
//   SKID  1: primary + skid register, in_ready registered
//         0: single register, in_ready = out_ready | ~out_valid
//
// Ports
//   clk          in   rising-edge clock
//   clrn         in   asynchronous active-low reset
//   in_valid     in   input beat valid
//   in_ready     out  stage can accept a beat
//   inst[31:0]   in   instruction word
//   pc[XLEN-1:0] in   PC of inst
//   flush        in   synchronous kill of held and incoming beats
//   out_valid    out  output beat valid
//   out_ready    in   downstream accepts the beat
//   out_imm      out  sign-extended immediate
//   out_fmt[2:0] out  0=N 1=I 2=SH 3=S 4=B 5=U 6=J
//   out_target   out  pc + out_imm modulo 2^XLEN
//   out_illegal  out  opcode not recognised
// -----------------------------------------------------------------------------
module imm_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_N  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_SH = 3'd2;
  localparam logic [2:0] FMT_S  = 3'd3;
  localparam logic [2:0] FMT_B  = 3'd4;
  localparam logic [2:0] FMT_U  = 3'd5;
  localparam logic [2:0] FMT_J  = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Packed beat layout: {illegal, fmt, imm, target}
  localparam int RW = 1 + 3 + 2 * XLEN;

  // Sign-extend a 32-bit signed value to XLEN.
  function automatic logic [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic            [XLEN-1:0] w_imm;
  logic            [2:0]      w_fmt;
  logic                       w_illegal;
  logic            [XLEN-1:0] w_target;
  logic            [31:0]     w_sh;
  logic signed     [31:0]     w_i_s;
  logic signed     [31:0]     w_s_s;
  logic signed     [31:0]     w_b_s;
  logic signed     [31:0]     w_u_s;
  logic signed     [31:0]     w_j_s;
  logic            [RW-1:0]   w_res_p0;

  logic                       w_in_rdy;
  logic                       w_acc;
  logic                       w_drain;

  logic                       r_pri_vld;
  logic            [RW-1:0]   r_pri_p1;

  // ---- stage 0: decode and target add ----
  assign w_i_s = {{20{inst[31]}}, inst[31:20]};
  assign w_s_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign w_b_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_u_s = {inst[31:12], 12'b0};
  assign w_j_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Shift amount is 6 bits wide on RV64, 5 bits on RV32; always zero-extended.
  assign w_sh = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};

  always_comb begin
    w_fmt     = FMT_N;
    w_imm     = '0;
    w_illegal = 1'b0;
    unique case (inst[6:0])
      OP_IMM: begin
        // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount.
        if (inst[13:12] == 2'b01) begin
          w_fmt = FMT_SH;
          w_imm = XLEN'(w_sh);
        end else begin
          w_fmt = FMT_I;
          w_imm = sext_xlen(w_i_s);
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        w_fmt = FMT_I;
        w_imm = sext_xlen(w_i_s);
      end
      OP_STORE: begin
        w_fmt = FMT_S;
        w_imm = sext_xlen(w_s_s);
      end
      OP_BRANCH: begin
        w_fmt = FMT_B;
        w_imm = sext_xlen(w_b_s);
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt = FMT_U;
        w_imm = sext_xlen(w_u_s);
      end
      OP_JAL: begin
        w_fmt = FMT_J;
        w_imm = sext_xlen(w_j_s);
      end
      OP_REG, OP_FENCE: begin
        w_fmt = FMT_N;
        w_imm = '0;
      end
      default: begin
        w_fmt     = FMT_N;
        w_imm     = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_target = pc + w_imm;
  assign w_res_p0 = {w_illegal, w_fmt, w_imm, w_target};

  // Flush discards the incoming beat even when the handshake completes.
  assign w_acc   = in_valid & w_in_rdy & ~flush;
  assign w_drain = r_pri_vld & out_ready;

  // ---- stage 1: output register(s) ----
  if (SKID) begin : g_skid
    logic          r_skd_vld;
    logic [RW-1:0] r_skd_p1;

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        r_pri_vld <= 1'b0;
        r_pri_p1  <= '0;
        r_skd_vld <= 1'b0;
        r_skd_p1  <= '0;
      end else if (flush) begin
        r_pri_vld <= 1'b0;
        r_skd_vld <= 1'b0;
      end else if (r_skd_vld) begin
        // in_ready is low here, so nothing new arrives; only the skid moves up.
        if (w_drain) begin
          r_pri_p1  <= r_skd_p1;
          r_skd_vld <= 1'b0;
        end
      end else if (w_acc) begin
        // The primary is free when empty or draining this cycle; that path
        // bypasses the skid register entirely.
        if (!r_pri_vld || out_ready) begin
          r_pri_p1  <= w_res_p0;
          r_pri_vld <= 1'b1;
        end else begin
          r_skd_p1  <= w_res_p0;
          r_skd_vld <= 1'b1;
        end
      end else if (w_drain) begin
        r_pri_vld <= 1'b0;
      end
    end

    // Registered ready: no combinational path from out_ready.
    assign w_in_rdy = ~r_skd_vld;
  end else begin : g_noskid
    assign w_in_rdy = out_ready | ~r_pri_vld;

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        r_pri_vld <= 1'b0;
        r_pri_p1  <= '0;
      end else if (flush) begin
        r_pri_vld <= 1'b0;
      end else if (w_in_rdy) begin
        r_pri_vld <= w_acc;
        if (w_acc) begin
          r_pri_p1 <= w_res_p0;
        end
      end
    end
  end

  assign in_ready  = w_in_rdy;
  assign out_valid = r_pri_vld;
  assign {out_illegal, out_fmt, out_imm, out_target} = r_pri_p1;

endmodule
